// File: rtl/jk_excite_seq.sv
// jk_excite_seq: stimulus and self-check engine for a downstream JK flip-flop.
// A captured WIDTH-bit pattern is played LSB first. J/K come from the JK
// excitation table, driven by the predicted flop state, never from q_fb.
// Sequence: IDLE -> INIT (flop reset) -> DRIVE x WIDTH -> CHECK -> DONE -> IDLE.
// In every DRIVE cycle and in CHECK, q_fb is compared with the predicted state.
// qb_fb must also be the complement of q_fb. A failing cycle bumps err_cnt
// once (saturating) and sets the sticky mismatch flag.
// Optional build macro: JK_SEQ_ABORT_EN. When it is defined, the first failed
// check ends the run: the block goes straight to DONE with err_cnt=1.
// Handshake: start is a level request. It is accepted only in IDLE, on the
// edge where start=1. Holding start high in any other state has no effect.
// o_dbg_state exposes the FSM state encoding for checkers.
module jk_excite_seq #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 4,
  parameter int DC_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             q_fb,
  input  logic             qb_fb,
  output logic             j,
  output logic             k,
  output logic             ff_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             mismatch,
  output logic [2:0]       o_dbg_state
);

  localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic            DC       = (DC_VAL != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_DRIVE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_pat, w_pat;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic             r_p, w_p;
  logic             r_j, w_j;
  logic             r_k, w_k;
  logic             r_ff_rst, w_ff_rst;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic [CNT_W-1:0] r_err, w_err;
  logic             r_mis, w_mis;

  logic             w_fail;
  logic             w_abort;
  logic [CNT_W-1:0] w_err_inc;
  logic [IDX_W-1:0] w_idx_inc;

  // Excitation table: {J,K} needed to move the flop from state p to state t.
  function automatic logic [1:0] excite(input logic p, input logic t);
    logic [1:0] jk;
    case ({p, t})
      2'b00:   jk = {1'b0, DC};
      2'b01:   jk = {1'b1, DC};
      2'b10:   jk = {DC, 1'b1};
      default: jk = {DC, 1'b0};
    endcase
    return jk;
  endfunction

  // r_p is the state the flop should show during the current cycle.
  assign w_fail    = (q_fb != r_p) || (qb_fb == q_fb);
  assign w_err_inc = (r_err == {CNT_W{1'b1}}) ? r_err : r_err + 1'b1;
  assign w_idx_inc = r_idx + 1'b1;

`ifdef JK_SEQ_ABORT_EN
  assign w_abort = w_fail;
`else
  assign w_abort = 1'b0;
`endif

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    w_state  = r_state;
    w_pat    = r_pat;
    w_idx    = r_idx;
    w_p      = r_p;
    w_j      = 1'b0;
    w_k      = 1'b0;
    w_ff_rst = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_err    = r_err;
    w_mis    = r_mis;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state  = S_INIT;
          w_pat    = pattern;
          w_err    = '0;
          w_mis    = 1'b0;
          w_idx    = '0;
          w_p      = 1'b0;
          w_ff_rst = 1'b1;
          w_busy   = 1'b1;
        end
      end
      S_INIT: begin
        // The flop is reset at the end of this cycle, so bit 0 starts from p=0.
        w_state      = S_DRIVE;
        w_idx        = '0;
        w_p          = 1'b0;
        {w_j, w_k}   = excite(1'b0, r_pat[0]);
        w_busy       = 1'b1;
      end
      S_DRIVE: begin
        if (w_fail) begin
          w_err = w_err_inc;
          w_mis = 1'b1;
        end
        if (w_abort) begin
          w_state = S_DONE;
          w_err   = CNT_W'(1);
          w_done  = 1'b1;
        end else if (r_idx == LAST_IDX) begin
          w_state = S_CHECK;
          w_p     = r_pat[r_idx];
          w_busy  = 1'b1;
        end else begin
          w_idx      = w_idx_inc;
          w_p        = r_pat[r_idx];
          {w_j, w_k} = excite(r_pat[r_idx], r_pat[w_idx_inc]);
          w_busy     = 1'b1;
        end
      end
      S_CHECK: begin
        if (w_fail) begin
          w_err = w_err_inc;
          w_mis = 1'b1;
        end
        if (w_abort) w_err = CNT_W'(1);
        w_state = S_DONE;
        w_done  = 1'b1;
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous active-low reset aborts any run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pat    <= '0;
      r_idx    <= '0;
      r_p      <= 1'b0;
      r_j      <= 1'b0;
      r_k      <= 1'b0;
      r_ff_rst <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= '0;
      r_mis    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pat    <= w_pat;
      r_idx    <= w_idx;
      r_p      <= w_p;
      r_j      <= w_j;
      r_k      <= w_k;
      r_ff_rst <= w_ff_rst;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
      r_mis    <= w_mis;
    end
  end

  assign j           = r_j;
  assign k           = r_k;
  assign ff_rst      = r_ff_rst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_cnt     = r_err;
  assign mismatch    = r_mis;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_jk_excite_seq.sv
// Bench for jk_excite_seq: three instances (default, DC_VAL=1, CNT_W=3),
// each driving its own behavioural JK flop. The flop feedback can be ideal,
// stuck at 0, or have qb equal to q.
module tb_jk_excite_seq;

`ifdef JK_SEQ_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  localparam int FB_IDEAL = 0;
  localparam int FB_STUCK = 1;
  localparam int FB_QBEQ  = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  int         fb_mode = FB_IDEAL;

  always #5 clk = ~clk;

  // ---------------- DUTs and flop models ----------------
  logic       j0, k0, ff_rst0, busy0, done0, mis0;
  logic [3:0] err0;
  logic [2:0] dbg0;
  logic       j1, k1, ff_rst1, busy1, done1, mis1;
  logic [3:0] err1;
  logic [2:0] dbg1;
  logic       j2, k2, ff_rst2, busy2, done2, mis2;
  logic [2:0] err2;
  logic [2:0] dbg2;
  logic       q0 = 1'b0, q1 = 1'b0, q2 = 1'b0;
  logic       qf0, qbf0, qf1, qbf1, qf2, qbf2;

  function automatic logic jk_next(input logic q, input logic jj, input logic kk, input logic r);
    if (r) return 1'b0;
    case ({jj, kk})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  always @(posedge clk) begin
    q0 <= jk_next(q0, j0, k0, ff_rst0);
    q1 <= jk_next(q1, j1, k1, ff_rst1);
    q2 <= jk_next(q2, j2, k2, ff_rst2);
  end

  assign qf0  = (fb_mode == FB_STUCK) ? 1'b0 : q0;
  assign qbf0 = (fb_mode == FB_QBEQ) ? qf0 : ~qf0;
  assign qf1  = (fb_mode == FB_STUCK) ? 1'b0 : q1;
  assign qbf1 = (fb_mode == FB_QBEQ) ? qf1 : ~qf1;
  assign qf2  = (fb_mode == FB_STUCK) ? 1'b0 : q2;
  assign qbf2 = (fb_mode == FB_QBEQ) ? qf2 : ~qf2;

  jk_excite_seq #(.WIDTH(8), .CNT_W(4), .DC_VAL(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .q_fb(qf0), .qb_fb(qbf0),
    .j(j0), .k(k0), .ff_rst(ff_rst0), .busy(busy0), .done(done0), .err_cnt(err0),
    .mismatch(mis0), .o_dbg_state(dbg0));

  jk_excite_seq #(.WIDTH(8), .CNT_W(4), .DC_VAL(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .q_fb(qf1), .qb_fb(qbf1),
    .j(j1), .k(k1), .ff_rst(ff_rst1), .busy(busy1), .done(done1), .err_cnt(err1),
    .mismatch(mis1), .o_dbg_state(dbg1));

  jk_excite_seq #(.WIDTH(8), .CNT_W(3), .DC_VAL(0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .q_fb(qf2), .qb_fb(qbf2),
    .j(j2), .k(k2), .ff_rst(ff_rst2), .busy(busy2), .done(done2), .err_cnt(err2),
    .mismatch(mis2), .o_dbg_state(dbg2));

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  logic [1:0] exp1_q[$];
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  // Reference excitation table {J,K} for p -> t with don't-care value dc.
  function automatic logic [1:0] excite_ref(input logic p, input logic t, input logic dc);
    if (!p && !t) return {1'b0, dc};
    if (!p &&  t) return {1'b1, dc};
    if ( p && !t) return {dc, 1'b1};
    return {dc, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  // One run: start at E0, observe each cycle at the falling edge n cycles after E0.
  task automatic run_pattern(input logic [7:0] pat, input bit chk_jk, input int exp_done,
                             input int exp_err0, input int exp_err2, input bit rand_start,
                             input string name);
    logic       p;
    logic [1:0] e;
    int         done_n;
    if (chk_jk) begin
      p = 1'b0;
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(excite_ref(p, pat[i], 1'b0));
        exp1_q.push_back(excite_ref(p, pat[i], 1'b1));
        p = pat[i];
      end
    end
    @(negedge clk);
    pattern = pat;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++; if (ff_rst0 !== 1'b1) $display("FAIL %s init_ff_rst: got %b want 1", name, ff_rst0); else pass_cnt++;
    chk_cnt++; if ({busy0, j0, k0} !== 3'b100) $display("FAIL %s init_busy_jk: got %b want 100", name, {busy0, j0, k0}); else pass_cnt++;
    chk_cnt++; if ({err0, mis0} !== 5'd0) $display("FAIL %s init_cleared: got err=%0d mis=%b want 0/0", name, err0, mis0); else pass_cnt++;
    done_n = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (chk_jk && n <= 8) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_cnt++; if ({j0, k0} !== e) $display("FAIL %s jk_dc0[%0d]: got %b want %b", name, n - 1, {j0, k0}, e); else pass_cnt++;
        end
        if (exp1_q.size() > 0) begin
          e = exp1_q.pop_front();
          chk_cnt++; if ({j1, k1} !== e) $display("FAIL %s jk_dc1[%0d]: got %b want %b", name, n - 1, {j1, k1}, e); else pass_cnt++;
        end
      end
      if (chk_jk && n == 9) begin
        chk_cnt++; if ({busy0, j0, k0} !== 3'b100) $display("FAIL %s check_cycle: got %b want 100", name, {busy0, j0, k0}); else pass_cnt++;
      end
      if (done0 === 1'b1) begin
        done_n = n;
        start  = 1'b0;
        break;
      end
      if (rand_start) start = 1'($urandom_range(0, 1));
      if (n == 3) pattern = ~pat;
    end
    start = 1'b0;
    exp_q.delete();
    exp1_q.delete();
    chk_cnt++; if (done_n != exp_done) $display("FAIL %s done_edge: got %0d want %0d", name, done_n, exp_done); else pass_cnt++;
    chk_cnt++; if (busy0 !== 1'b0) $display("FAIL %s busy_in_done: got %b want 0", name, busy0); else pass_cnt++;
    chk_cnt++; if (int'(err0) != exp_err0) $display("FAIL %s err_cnt: got %0d want %0d", name, err0, exp_err0); else pass_cnt++;
    chk_cnt++; if (mis0 !== (exp_err0 != 0)) $display("FAIL %s mismatch: got %b want %b", name, mis0, exp_err0 != 0); else pass_cnt++;
    chk_cnt++; if (int'(err2) != exp_err2) $display("FAIL %s err_cnt_w3: got %0d want %0d", name, err2, exp_err2); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({done0, busy0} !== 2'b00) $display("FAIL %s done_pulse: got %b want 00", name, {done0, busy0}); else pass_cnt++;
    chk_cnt++; if (int'(err0) != exp_err0) $display("FAIL %s err_hold: got %0d want %0d", name, err0, exp_err0); else pass_cnt++;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    repeat (3) @(negedge clk);
    chk_cnt++; if ({j0, k0, ff_rst0, busy0, done0, mis0} !== 6'd0) $display("FAIL reset_outs: got %b want 000000", {j0, k0, ff_rst0, busy0, done0, mis0}); else pass_cnt++;
    chk_cnt++; if (err0 !== 4'd0) $display("FAIL reset_err: got %0d want 0", err0); else pass_cnt++;
    chk_cnt++; if ({j1, k1, busy1, err2} !== 6'd0) $display("FAIL reset_others: got %b want 0", {j1, k1, busy1, err2}); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({busy0, ff_rst0, done0} !== 3'b000) $display("FAIL idle_no_start: got %b want 000", {busy0, ff_rst0, done0}); else pass_cnt++;
  endtask

  task automatic test_ideal();
    fb_mode = FB_IDEAL;
    run_pattern(8'b1011_0010, 1'b1, 10, 0, 0, 1'b0, "ideal_b2");
  endtask

  task automatic test_start_pulses();
    fb_mode = FB_IDEAL;
    run_pattern(8'h69, 1'b1, 10, 0, 0, 1'b1, "pulses_69");
  endtask

  task automatic test_stuck_q();
    fb_mode = FB_STUCK;
    run_pattern(8'hFF, 1'b0, ABORT ? 3 : 10, ABORT ? 1 : 8, ABORT ? 1 : 7, 1'b0, "stuck_ff");
    fb_mode = FB_IDEAL;
  endtask

  task automatic test_qb_equal();
    fb_mode = FB_QBEQ;
    run_pattern(8'h5A, 1'b0, ABORT ? 2 : 10, ABORT ? 1 : 9, ABORT ? 1 : 7, 1'b0, "qbeq_5a");
    fb_mode = FB_IDEAL;
  endtask

  task automatic test_reset_mid_run();
    fb_mode = FB_STUCK;
    @(negedge clk);
    pattern = 8'hAA;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_cnt++; if ({j0, k0, ff_rst0, busy0, done0} !== 5'd0) $display("FAIL midrst_outs: got %b want 00000", {j0, k0, ff_rst0, busy0, done0}); else pass_cnt++;
    chk_cnt++; if ({err0, mis0} !== 5'd0) $display("FAIL midrst_err: got err=%0d mis=%b want 0/0", err0, mis0); else pass_cnt++;
    chk_cnt++; if (err2 !== 3'd0) $display("FAIL midrst_err_w3: got %0d want 0", err2); else pass_cnt++;
    @(negedge clk);
    reset   = 1'b1;
    fb_mode = FB_IDEAL;
    run_pattern(8'hA5, 1'b1, 10, 0, 0, 1'b0, "after_reset_a5");
  endtask

  task automatic test_start_held();
    int rst_seen;
    int done_n;
    fb_mode = FB_IDEAL;
    rst_seen = 0;
    done_n   = -1;
    @(negedge clk);
    pattern = 8'h3C;
    start   = 1'b1;
    @(negedge clk);
    chk_cnt++; if (ff_rst0 !== 1'b1) $display("FAIL held_first_init: got %b want 1", ff_rst0); else pass_cnt++;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (ff_rst0 === 1'b1) rst_seen++;
      if (done0 === 1'b1 && done_n < 0) done_n = n;
    end
    chk_cnt++; if (rst_seen != 0) $display("FAIL held_no_restart: got %0d want 0", rst_seen); else pass_cnt++;
    chk_cnt++; if (done_n != 10) $display("FAIL held_done_edge: got %0d want 10", done_n); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({ff_rst0, busy0} !== 2'b11) $display("FAIL held_second_init: got %b want 11", {ff_rst0, busy0}); else pass_cnt++;
    start  = 1'b0;
    done_n = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        done_n = n;
        break;
      end
    end
    chk_cnt++; if (done_n != 10) $display("FAIL held_second_done: got %0d want 10", done_n); else pass_cnt++;
    chk_cnt++; if ({err0, mis0} !== 5'd0) $display("FAIL held_second_err: got err=%0d mis=%b want 0/0", err0, mis0); else pass_cnt++;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ideal();
    test_start_pulses();
    test_stuck_q();
    test_qb_equal();
    test_reset_mid_run();
    test_start_held();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_excite_seq.md
Name: jk_excite_seq

Overview:
- Drives the J/K inputs of a downstream JK flip-flop so that its Q output follows a loaded bit pattern.
- Derives J/K from the JK excitation table, resets the flop first, then checks Q/QB feedback every cycle and counts mismatches.
- Serves as stimulus and self-check engine for JK flip-flop instances, and as a serial pattern player built on them.

Parameters:
- WIDTH, 8, pattern length in bits (>=2).
- CNT_W, 4, error counter width; counter saturates at 2^CNT_W-1.
- DC_VAL, 0, value driven on excitation-table don't-care J/K positions (0 or 1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets the block immediately).
- start  input  1  request to run; sampled only in IDLE.
- pattern  input  WIDTH  target Q sequence, captured on start, played LSB first.
- q_fb  input  1  Q from the driven flop.
- qb_fb  input  1  QB from the driven flop.
- j  output  1  registered J to the flop.
- k  output  1  registered K to the flop.
- ff_rst  output  1  registered synchronous active-high reset to the flop.
- busy  output  1  high in INIT, DRIVE, CHECK.
- done  output  1  one-cycle pulse in DONE.
- err_cnt  output  CNT_W  mismatch count of the last or current run.
- mismatch  output  1  sticky; set by any check failure in the run.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; j=k=ff_rst=busy=done=mismatch=0; err_cnt=0; pattern register, bit index and predicted state=0.
- States: IDLE, INIT, DRIVE, CHECK, DONE. All outputs are registered.
- IDLE:
  - start=1 captures pattern, clears err_cnt and mismatch, and goes to INIT.
  - start is ignored in every other state.
- INIT, 1 cycle:
  - ff_rst=1, j=k=0, predicted state p=0.
  - Goes to DRIVE with idx=0.
- DRIVE, WIDTH cycles, idx 0..WIDTH-1. Target t=pattern[idx]; J/K come from p->t:
  - 0->0: J=0, K=DC_VAL.
  - 0->1: J=1, K=DC_VAL.
  - 1->0: J=DC_VAL, K=1.
  - 1->1: J=DC_VAL, K=0.
  - After each DRIVE cycle, p<=t.
  - p is the predicted state; q_fb is never used to compute J/K (no feedback loop).
- Checks:
  - In every DRIVE cycle and in CHECK, compare q_fb against the expected value.
  - Expected value is 0 for idx=0 (post-INIT) and pattern[idx-1] otherwise; in CHECK it is pattern[WIDTH-1].
  - Also require qb_fb == ~q_fb.
  - Either failure in a cycle increments err_cnt by 1 (saturating) and sets mismatch. Two failures in one cycle still count once.
  - INIT and DONE perform no checks.
- CHECK, 1 cycle: j=k=0 (flop holds), final check, then DONE.
- DONE, 1 cycle: done=1, busy=0, j=k=0, then IDLE.
  - err_cnt and mismatch hold until the next accepted start.
- Latency: start sampled at edge E0 gives INIT after E0 and done high after edge E0+WIDTH+2. A run is WIDTH+3 cycles including DONE.
- Asynchronous reset mid-run aborts at once. Outputs return to reset values and the flop is left unreset; the next run re-initialises it through INIT.
- A pattern change during a run has no effect (captured copy is used).

Optional Feature:
- Macro JK_SEQ_ABORT_EN.
- Defined: the first check failure in DRIVE or CHECK sets err_cnt=1 and mismatch=1, forces j=k=0, and jumps directly to DONE on the next edge, skipping remaining bits.
- Undefined: the run always completes all WIDTH bits and counts every failure.

Test Plan:
- Ideal JK model, DC_VAL=0, pattern=8'b1011_0010, start pulse -> (J,K) per DRIVE cycle = 00,10,01,00,10,00,01,10. done high exactly after edge E0+10, err_cnt=0, mismatch=0.
- Same with DC_VAL=1 -> (J,K) = 01,11,11,01,11,10,11,11. Model Q still follows pattern; err_cnt=0.
- Model Q stuck at 0, qb=~q, pattern=8'hFF -> idx0 check passes and the 8 later checks fail, giving err_cnt=8, mismatch=1. With JK_SEQ_ABORT_EN: done after edge E0+3, err_cnt=1.
- Model with qb_fb=q_fb, otherwise ideal, pattern=8'h5A -> all 9 checks fail, err_cnt=9. With CNT_W=3: err_cnt saturates at 7.
- reset driven low during DRIVE idx=3 -> same cycle j=k=ff_rst=busy=0 and err_cnt=0. After release, a start with pattern 8'hA5 completes cleanly with err_cnt=0.
- start held high through an entire run -> the second run starts only from IDLE after DONE. start pulses during busy do not restart, extend, or corrupt the run.
